scalar_write_back_unit: RTL and testbench

- Write-back stage directly upstream of the scalar register file.
- Collects scalar results from the scalar ALU and from the load path (LSU), buffers them in an in-order FIFO, and retires one result per cycle onto the register file write port (rf_signal, rd, data, write_back_enabled).
- Exports a pending-destination mask so decode can stall on RAW hazards against results not yet written.

---
 rtl/scalar_write_back_unit.sv | 151 +++++++++++++++
 tb/tb_scalar_write_back_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/scalar_write_back_unit.sv
// rtl/scalar_write_back_unit.sv - in-order write-back FIFO feeding the scalar register file; optional bypass lookup under SCALAR_WB_BYPASS_EN
`ifndef SCALAR_RF_WRITE
`define SCALAR_RF_WRITE 2'b01
`endif

module scalar_write_back_unit #(
    parameter int SCALAR_REG_LEN = 64,
    parameter int WB_FIFO_DEPTH  = 4,
    parameter int WB_PTR_WIDTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy_in,
    input  logic                      alu_valid,
    input  logic [4:0]                alu_rd,
    input  logic [SCALAR_REG_LEN-1:0] alu_data,
    output logic                      alu_ready,
    input  logic                      mem_valid,
    input  logic [4:0]                mem_rd,
    input  logic [SCALAR_REG_LEN-1:0] mem_data,
    output logic                      mem_ready,
    output logic [1:0]                rf_signal,
    output logic [4:0]                rd,
    output logic [SCALAR_REG_LEN-1:0] data,
    output logic                      write_back_enabled,
    output logic [31:0]               pending_mask,
`ifdef SCALAR_WB_BYPASS_EN
    input  logic [4:0]                byp_rs1,
    input  logic [4:0]                byp_rs2,
    output logic                      byp_rs1_hit,
    output logic                      byp_rs2_hit,
    output logic [SCALAR_REG_LEN-1:0] byp_rs1_data,
    output logic [SCALAR_REG_LEN-1:0] byp_rs2_data,
`endif
    output logic                      wb_empty
);

    localparam int CNT_W = WB_PTR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WB_FIFO_DEPTH);

    logic [WB_PTR_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [WB_FIFO_DEPTH-1:0]  valid_q, valid_d;
    logic [4:0]                rd_q   [WB_FIFO_DEPTH];
    logic [4:0]                rd_d   [WB_FIFO_DEPTH];
    logic [SCALAR_REG_LEN-1:0] data_q [WB_FIFO_DEPTH];
    logic [SCALAR_REG_LEN-1:0] data_d [WB_FIFO_DEPTH];

    logic [CNT_W-1:0]        free;
    logic                    empty;
    logic                    mem_store, alu_store;
    logic [WB_PTR_WIDTH-1:0] wr_ptr;

    // Handshake: readies come from the registered count only; a load takes the first free slot
    always_comb begin
        free       = DEPTH_C - count_q;
        empty      = (count_q == '0);
        mem_ready  = rst && rdy_in && (free >= CNT_W'(1));
        alu_ready  = rst && rdy_in && (mem_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1)));
        mem_store  = mem_valid && mem_ready && (mem_rd != 5'd0);
        alu_store  = alu_valid && alu_ready && (alu_rd != 5'd0);
        write_back_enabled = rdy_in && !empty;
    end

    // Next state: pop the head, then push load then ALU at consecutive tail slots
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        wr_ptr  = tail_q;
        if (write_back_enabled) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + WB_PTR_WIDTH'(1);
        end
        if (mem_store) begin
            valid_d[wr_ptr] = 1'b1;
            rd_d[wr_ptr]    = mem_rd;
            data_d[wr_ptr]  = mem_data;
            wr_ptr          = wr_ptr + WB_PTR_WIDTH'(1);
        end
        if (alu_store) begin
            valid_d[wr_ptr] = 1'b1;
            rd_d[wr_ptr]    = alu_rd;
            data_d[wr_ptr]  = alu_data;
            wr_ptr          = wr_ptr + WB_PTR_WIDTH'(1);
        end
        tail_d  = wr_ptr;
        count_d = count_q + CNT_W'(mem_store) + CNT_W'(alu_store) - CNT_W'(write_back_enabled);
    end

    // State registers; rdy_in=0 already suppresses every push and pop so state holds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    // Register-file port driven straight from the head entry; pending mask over valid entries
    always_comb begin
        rf_signal    = write_back_enabled ? `SCALAR_RF_WRITE : 2'b00;
        rd           = empty ? 5'd0 : rd_q[head_q];
        data         = empty ? '0 : data_q[head_q];
        wb_empty     = empty;
        pending_mask = '0;
        for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            if (valid_q[i]) pending_mask[rd_q[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

`ifdef SCALAR_WB_BYPASS_EN
    logic [WB_PTR_WIDTH-1:0] byp_idx;

    // Walk oldest to youngest so the youngest matching entry wins
    always_comb begin
        byp_rs1_hit  = 1'b0;
        byp_rs2_hit  = 1'b0;
        byp_rs1_data = '0;
        byp_rs2_data = '0;
        byp_idx      = head_q;
        for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            byp_idx = head_q + WB_PTR_WIDTH'(i);
            if (valid_q[byp_idx] && (byp_rs1 != 5'd0) && (rd_q[byp_idx] == byp_rs1)) begin
                byp_rs1_hit  = 1'b1;
                byp_rs1_data = data_q[byp_idx];
            end
            if (valid_q[byp_idx] && (byp_rs2 != 5'd0) && (rd_q[byp_idx] == byp_rs2)) begin
                byp_rs2_hit  = 1'b1;
                byp_rs2_data = data_q[byp_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_scalar_write_back_unit.sv
// tb/tb_scalar_write_back_unit.sv - directed self-checking bench for scalar_write_back_unit
`ifndef SCALAR_RF_WRITE
`define SCALAR_RF_WRITE 2'b01
`endif

module tb_scalar_write_back_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy_in;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [63:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic [1:0]  rf_signal;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        write_back_enabled;
    logic [31:0] pending_mask;
    logic        wb_empty;

    int errors = 0;
    int checks = 0;

    scalar_write_back_unit dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_signal(rf_signal), .rd(rd), .data(data),
        .write_back_enabled(write_back_enabled), .pending_mask(pending_mask),
        .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy_in = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd7;  alu_data = 64'hDEAD;
        mem_valid = 1'b1; mem_rd = 5'd9;  mem_data = 64'hBEEF;
        tick(); tick();
        checks++; if (write_back_enabled !== 1'b0) begin errors++; $display("FAIL rst_wbe got=%0h exp=0", write_back_enabled); end
        checks++; if (rf_signal !== 2'b00) begin errors++; $display("FAIL rst_rf_signal got=%0h exp=0", rf_signal); end
        checks++; if (rd !== 5'd0) begin errors++; $display("FAIL rst_rd got=%0h exp=0", rd); end
        checks++; if (data !== 64'd0) begin errors++; $display("FAIL rst_data got=%0h exp=0", data); end
        checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL rst_pending got=%0h exp=0", pending_mask); end
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%0h exp=1", wb_empty); end
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready got=%0h exp=0", alu_ready); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_ready got=%0h exp=0", mem_ready); end
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL idle_empty got=%0h exp=1", wb_empty); end
        checks++; if (write_back_enabled !== 1'b0) begin errors++; $display("FAIL idle_wbe got=%0h exp=0", write_back_enabled); end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready got=%0h exp=1", alu_ready); end
        tick();
        clear_inputs();
        #1;
        checks++; if (write_back_enabled !== 1'b1) begin errors++; $display("FAIL single_wbe got=%0h exp=1", write_back_enabled); end
        checks++; if (rf_signal !== `SCALAR_RF_WRITE) begin errors++; $display("FAIL single_rf_signal got=%0h exp=%0h", rf_signal, `SCALAR_RF_WRITE); end
        checks++; if (rd !== 5'd5) begin errors++; $display("FAIL single_rd got=%0d exp=5", rd); end
        checks++; if (data !== 64'h1234) begin errors++; $display("FAIL single_data got=%0h exp=1234", data); end
        checks++; if (pending_mask !== 32'h20) begin errors++; $display("FAIL single_pending got=%0h exp=20", pending_mask); end
        tick();
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL single_after_empty got=%0h exp=1", wb_empty); end
        checks++; if (write_back_enabled !== 1'b0) begin errors++; $display("FAIL single_after_wbe got=%0h exp=0", write_back_enabled); end
    endtask

    task automatic test_simultaneous();
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'd7;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'd9;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL sim_mem_ready got=%0h exp=1", mem_ready); end
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL sim_alu_ready got=%0h exp=1", alu_ready); end
        tick();
        clear_inputs();
        #1;
        checks++; if (pending_mask !== 32'h18) begin errors++; $display("FAIL sim_pending got=%0h exp=18", pending_mask); end
        checks++; if (write_back_enabled !== 1'b1 || rd !== 5'd3 || data !== 64'd7) begin errors++; $display("FAIL sim_first got=%0h/%0d/%0h exp=1/3/7", write_back_enabled, rd, data); end
        tick();
        checks++; if (write_back_enabled !== 1'b1 || rd !== 5'd4 || data !== 64'd9) begin errors++; $display("FAIL sim_second got=%0h/%0d/%0h exp=1/4/9", write_back_enabled, rd, data); end
        checks++; if (pending_mask !== 32'h10) begin errors++; $display("FAIL sim_pending2 got=%0h exp=10", pending_mask); end
        tick();
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL sim_drained got=%0h exp=1", wb_empty); end
    endtask

    task automatic test_full();
        logic [4:0]  exp_rd   [3];
        logic [63:0] exp_data [3];
        exp_rd[0] = 5'd12; exp_data[0] = 64'hC0;
        exp_rd[1] = 5'd13; exp_data[1] = 64'hD0;
        exp_rd[2] = 5'd14; exp_data[2] = 64'hE0;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 64'hA0;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 64'hB0;
        tick();
        mem_rd = 5'd12; mem_data = 64'hC0;
        alu_rd = 5'd13; alu_data = 64'hD0;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL fill_alu_ready got=%0h exp=1", alu_ready); end
        checks++; if (write_back_enabled !== 1'b1 || rd !== 5'd10) begin errors++; $display("FAIL fill_head got=%0h/%0d exp=1/10", write_back_enabled, rd); end
        tick();
        rdy_in = 1'b0;
        mem_rd = 5'd14; mem_data = 64'hE0;
        alu_rd = 5'd15; alu_data = 64'hF0;
        #1;
        checks++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got=%0h/%0h exp=0/0", mem_ready, alu_ready); end
        checks++; if (write_back_enabled !== 1'b0) begin errors++; $display("FAIL hold_wbe got=%0h exp=0", write_back_enabled); end
        checks++; if (pending_mask !== 32'h3800) begin errors++; $display("FAIL hold_pending got=%0h exp=3800", pending_mask); end
        tick();
        checks++; if (pending_mask !== 32'h3800 || wb_empty !== 1'b0) begin errors++; $display("FAIL hold_kept got=%0h/%0h exp=3800/0", pending_mask, wb_empty); end
        rdy_in = 1'b1;
        #1;
        checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL one_free_ready got=%0h/%0h exp=1/0", mem_ready, alu_ready); end
        checks++; if (write_back_enabled !== 1'b1 || rd !== 5'd11 || data !== 64'hB0) begin errors++; $display("FAIL resume_head got=%0h/%0d/%0h exp=1/11/b0", write_back_enabled, rd, data); end
        tick();
        clear_inputs();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (write_back_enabled !== 1'b1 || rd !== exp_rd[i] || data !== exp_data[i]) begin
                errors++;
                $display("FAIL drain_%0d got=%0h/%0d/%0h exp=1/%0d/%0h", i, write_back_enabled, rd, data, exp_rd[i], exp_data[i]);
            end
            tick();
        end
        checks++; if (wb_empty !== 1'b1 || pending_mask !== 32'd0) begin errors++; $display("FAIL drain_empty got=%0h/%0h exp=1/0", wb_empty, pending_mask); end
    endtask

    task automatic test_zero_reg();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL zero_alu_ready got=%0h exp=1", alu_ready); end
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (write_back_enabled !== 1'b0 || pending_mask !== 32'd0 || wb_empty !== 1'b1) begin
                errors++;
                $display("FAIL zero_no_write_%0d got=%0h/%0h/%0h exp=0/0/1", i, write_back_enabled, pending_mask, wb_empty);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 64'h20;
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 64'h21;
        tick();
        mem_rd = 5'd22; mem_data = 64'h22;
        alu_rd = 5'd23; alu_data = 64'h23;
        tick();
        clear_inputs();
        #1;
        checks++; if (pending_mask !== 32'h00E0_0000 || wb_empty !== 1'b0) begin errors++; $display("FAIL arst_pre got=%0h/%0h exp=e00000/0", pending_mask, wb_empty); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (write_back_enabled !== 1'b0 || wb_empty !== 1'b1 || pending_mask !== 32'd0) begin errors++; $display("FAIL arst_clear got=%0h/%0h/%0h exp=0/1/0", write_back_enabled, wb_empty, pending_mask); end
        checks++; if (rd !== 5'd0 || data !== 64'd0 || rf_signal !== 2'b00) begin errors++; $display("FAIL arst_port got=%0d/%0h/%0h exp=0/0/0", rd, data, rf_signal); end
        checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got=%0h/%0h exp=0/0", alu_ready, mem_ready); end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (write_back_enabled !== 1'b0 || wb_empty !== 1'b1) begin
                errors++;
                $display("FAIL arst_after_%0d got=%0h/%0h exp=0/1", i, write_back_enabled, wb_empty);
            end
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_full();
        test_zero_reg();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
